// File: rtl/grid_move_engine.sv
// 2048 move engine: captures a grid and a direction, then compacts and merges
// one line per clock before reporting the new grid, score, moved and win.
module gme_line #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int SCORE_W = 32
) (
  input  logic [N-1:0][W-1:0] line_in,
  output logic [N-1:0][W-1:0] line_out,
  output logic [SCORE_W-1:0]  score
);
  localparam logic [W-1:0] EMAX = '1;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] merge_pts(input logic [W-1:0] e);
    if (int'(e) + 1 >= SCORE_W) return '1;
    return {{(SCORE_W-1){1'b0}}, 1'b1} << (int'(e) + 1);
  endfunction

  logic [N-1:0][W-1:0] b, c;
  logic [SCORE_W-1:0]  sc;
  int                  idx;

  // Index 0 is the front of the line; a merge zeroes the partner, so the
  // next pair can never reuse a freshly merged tile.
  always_comb begin
    b   = '0;
    c   = '0;
    sc  = '0;
    idx = 0;
    for (int i = 0; i < N; i++)
      if (line_in[i] != '0) begin
        b[idx] = line_in[i];
        idx++;
      end
    for (int i = 0; i < N-1; i++)
      if (b[i] != '0 && b[i] == b[i+1] && b[i] != EMAX) begin
        sc     = sat_add(sc, merge_pts(b[i]));
        b[i]   = b[i] + 1'b1;
        b[i+1] = '0;
      end
    idx = 0;
    for (int i = 0; i < N; i++)
      if (b[i] != '0) begin
        c[idx] = b[i];
        idx++;
      end
    line_out = c;
    score    = sc;
  end
endmodule

module grid_move_engine #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         dir,
  input  logic [N*N*W-1:0]   grid_in,
  output logic               busy,
  output logic               done,
  output logic [N*N*W-1:0]   grid_out,
  output logic               moved,
  output logic [SCORE_W-1:0] score_delta,
  output logic               win
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [N*N-1:0][W-1:0]   grid, orig, ng;
  logic [1:0]              dir_q;
  logic [KW-1:0]           k;
  logic [SCORE_W-1:0]      acc, acc_nxt, lscore;
  logic [N-1:0][W-1:0]     lin, lout;
  logic                    win_nxt;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  // Cell index of position j (0 = front) within line kk for direction d.
  function automatic int cidx(input logic [1:0] d, input int kk, input int j);
    case (d)
      2'd0:    return kk*N + j;
      2'd1:    return kk*N + (N-1-j);
      2'd2:    return j*N + kk;
      default: return (N-1-j)*N + kk;
    endcase
  endfunction

  always_comb begin
    lin = '0;
    for (int j = 0; j < N; j++)
      lin[j] = grid[cidx(dir_q, int'(k), j)];
  end

  gme_line #(.N(N), .W(W), .SCORE_W(SCORE_W)) u_line (
    .line_in  (lin),
    .line_out (lout),
    .score    (lscore)
  );

  assign acc_nxt = sat_add(acc, lscore);

  always_comb begin
    ng      = grid;
    win_nxt = 1'b0;
    for (int j = 0; j < N; j++)
      ng[cidx(dir_q, int'(k), j)] = lout[j];
    for (int i = 0; i < N*N; i++)
      if (int'(ng[i]) >= WIN_EXP) win_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      grid        <= '0;
      orig        <= '0;
      dir_q       <= '0;
      k           <= '0;
      acc         <= '0;
      grid_out    <= '0;
      moved       <= 1'b0;
      score_delta <= '0;
      win         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            grid  <= grid_in;
            orig  <= grid_in;
            dir_q <= dir;
            k     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          grid <= ng;
          acc  <= acc_nxt;
          k    <= k + 1'b1;
          if (k == KLAST) begin
            state       <= DONE;
            done        <= 1'b1;
            grid_out    <= ng;
            moved       <= (ng != orig);
            score_delta <= acc_nxt;
            win         <= win_nxt;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_move_engine.sv
// Directed bench for grid_move_engine at N=4, W=4: move results, latency,
// saturation, win, ignored starts, back-to-back starts and async reset.
module tb_grid_move_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  dir;
  logic [63:0] grid_in;
  logic        busy, done, moved, win;
  logic [63:0] grid_out;
  logic [31:0] score_delta;

  int checks = 0;
  int failures = 0;
  int lat, ndone, cyc, d1, d2;

  grid_move_engine #(.N(4), .W(4), .WIN_EXP(11), .SCORE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .grid_in(grid_in),
    .busy(busy), .done(done), .grid_out(grid_out), .moved(moved),
    .score_delta(score_delta), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] put(input logic [63:0] g, input int r, input int c,
                                      input int v);
    logic [63:0] t;
    t = g;
    t[(r*4+c)*4 +: 4] = v[3:0];
    return t;
  endfunction

  function automatic logic [63:0] row0(input int a, input int b, input int c, input int d);
    return put(put(put(put(64'h0, 0, 0, a), 0, 1, b), 0, 2, c), 0, 3, d);
  endfunction

  // Issue one move and wait for done; lat counts cycles from the accepting edge.
  task automatic run_move(input logic [1:0] d, input logic [63:0] g);
    @(negedge clk);
    dir = d; grid_in = g; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; grid_in = '1; dir = ~d;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [63:0] gu, eu, ed;

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 2'd0; grid_in = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_grid", grid_out, 0);
    chk("reset_score", score_delta, 0);
    @(negedge clk); rst_n = 1'b1;

    run_move(2'd0, row0(1, 1, 2, 2));
    chk("l1_latency", lat, 5);
    chk("l1_busy_in_done", busy, 1);
    chk("l1_grid", grid_out, row0(2, 3, 0, 0));
    chk("l1_score", score_delta, 12);
    chk("l1_moved", moved, 1);
    chk("l1_win", win, 0);
    @(negedge clk);
    chk("l1_done_pulse", done, 0);
    chk("l1_idle_busy", busy, 0);
    chk("l1_hold_grid", grid_out, row0(2, 3, 0, 0));

    run_move(2'd0, row0(1, 1, 1, 1));
    chk("l2_grid", grid_out, row0(2, 2, 0, 0));
    chk("l2_score", score_delta, 8);

    run_move(2'd1, row0(0, 2, 0, 2));
    chk("r1_grid", grid_out, row0(0, 0, 0, 3));
    chk("r1_score", score_delta, 8);

    // col0 = [0,0,3,3], col1 = [4,0,4,5] top to bottom; 3+3 -> 16, 4+4 -> 32
    gu = put(put(put(put(put(64'h0, 2, 0, 3), 3, 0, 3), 0, 1, 4), 2, 1, 4), 3, 1, 5);
    eu = put(put(put(64'h0, 0, 0, 4), 0, 1, 5), 1, 1, 5);
    ed = put(put(put(64'h0, 3, 0, 4), 2, 1, 5), 3, 1, 5);
    run_move(2'd2, gu);
    chk("u1_latency", lat, 5);
    chk("u1_grid", grid_out, eu);
    chk("u1_score", score_delta, 48);
    run_move(2'd3, gu);
    chk("d1_grid", grid_out, ed);
    chk("d1_score", score_delta, 48);
    chk("d1_moved", moved, 1);

    run_move(2'd0, row0(1, 2, 3, 4));
    chk("nop_latency", lat, 5);
    chk("nop_grid", grid_out, row0(1, 2, 3, 4));
    chk("nop_moved", moved, 0);
    chk("nop_score", score_delta, 0);

    run_move(2'd0, row0(15, 15, 0, 0));
    chk("sat_grid", grid_out, row0(15, 15, 0, 0));
    chk("sat_moved", moved, 0);
    chk("sat_score", score_delta, 0);
    chk("sat_win", win, 1);

    run_move(2'd0, row0(10, 10, 0, 0));
    chk("win_grid", grid_out, row0(11, 0, 0, 0));
    chk("win_flag", win, 1);
    chk("win_score", score_delta, 2048);

    // second start pulse lands in RUN and must be dropped
    @(negedge clk);
    dir = 2'd0; grid_in = row0(1, 1, 0, 0); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; grid_in = row0(3, 3, 3, 3);
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_grid", grid_out, row0(2, 0, 0, 0));
    chk("ign_win_cleared", win, 0);
    chk("ign_score", score_delta, 4);

    // start held high: moves every N+2 cycles
    dir = 2'd1; grid_in = row0(1, 1, 0, 0); start = 1'b1;
    d1 = -1; d2 = -1;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (done && d1 < 0) d1 = cyc;
      else if (done && d2 < 0) d2 = cyc;
    end
    start = 1'b0;
    chk("b2b_spacing", (d1 >= 0 && d2 >= 0) ? d2 - d1 : -1, 6);
    chk("b2b_grid", grid_out, row0(0, 0, 0, 2));
    repeat (8) @(negedge clk);

    // async reset in the middle of RUN
    run_move(2'd0, row0(4, 4, 0, 0));
    chk("pre_rst_score", score_delta, 32);
    @(negedge clk);
    dir = 2'd0; grid_in = row0(2, 2, 0, 0); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_grid", grid_out, 0);
    chk("rst_moved", moved, 0);
    chk("rst_score", score_delta, 0);
    chk("rst_win", win, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_done", grid_out, 0);

    run_move(2'd0, row0(2, 2, 0, 0));
    chk("post_rst_latency", lat, 5);
    chk("post_rst_grid", grid_out, row0(3, 0, 0, 0));
    chk("post_rst_score", score_delta, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
